// File: rtl/br_tag_manager_pkg.sv
// Shared branch-tag types: mask width, broadcast task encoding
// and address width used by dispatch, RS, FUs and ROB.
package br_tag_manager_pkg;

  localparam int N_BR_DEF = 4;
  localparam int ADDR_W   = 32;

  typedef logic [N_BR_DEF-1:0] br_mask_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } br_task_t;

endpackage

// File: rtl/br_tag_manager_psel.sv
// Lowest-index-first one-hot priority selector.
// any_o flags that at least one request bit is set.
module br_psel #(
  parameter int W = 4
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] gnt_o,
  output logic         any_o
);

  logic [W-1:0] one;

  assign one   = {{(W-1){1'b0}}, 1'b1};
  assign gnt_o = req_i & (~req_i + one);
  assign any_o = |req_i;

endmodule

// File: rtl/br_tag_manager.sv
// Branch tag manager: one-hot b_id allocation, dependency tracking,
// and registered CLEAR/SQUASH broadcast plus fetch redirect.
module br_tag_manager
  import br_tag_manager_pkg::*;
#(
  parameter int N_BR = N_BR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [N_BR-1:0]   alloc_b_id,
  output logic [N_BR-1:0]   cur_b_mask,
  output logic              full,
  input  logic              res_valid,
  input  br_task_t          res_task,
  input  logic [N_BR-1:0]   res_b_id,
  input  logic [ADDR_W-1:0] res_target,
  output br_task_t          rem_br_task,
  output logic [N_BR-1:0]   rem_b_id,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc
);

  logic [N_BR-1:0]   busy_q, busy_d;
  logic [N_BR-1:0]   dep_q [N_BR];
  logic [N_BR-1:0]   dep_d [N_BR];
  logic              full_q, full_d;
  br_task_t          task_q, task_d;
  logic [N_BR-1:0]   rid_q, rid_d;
  logic              rv_q, rv_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;

  logic [N_BR-1:0] pick;
  logic            any_free;
  logic            one_hot;
  logic            res_ok;
  logic            is_clr;
  logic            is_sq;
  logic [N_BR-1:0] clr_bits;
  logic [N_BR-1:0] kill;

  br_psel #(.W(N_BR)) u_psel (
    .req_i (~busy_q),
    .gnt_o (pick),
    .any_o (any_free)
  );

  assign one_hot = (res_b_id != '0) &&
                   ((res_b_id & (res_b_id - 1'b1)) == '0);
  assign res_ok  = res_valid && one_hot &&
                   ((res_b_id & busy_q) != '0);
  assign is_clr  = res_ok && (res_task == CLEAR);
  assign is_sq   = res_ok && (res_task == SQUASH);

  // A dispatching branch alongside a squash is on the wrong path.
  assign alloc_gnt  = alloc_req && any_free && !is_sq;
  assign alloc_b_id = alloc_gnt ? pick : '0;
  assign clr_bits   = is_clr ? res_b_id : '0;

  always_comb begin
    kill = '0;
    if (is_sq) begin
      kill = res_b_id;
      for (int j = 0; j < N_BR; j++)
        if ((dep_q[j] & res_b_id) != '0)
          kill[j] = 1'b1;
    end
  end

  always_comb begin
    busy_d = (busy_q & ~clr_bits & ~kill) | alloc_b_id;
    for (int j = 0; j < N_BR; j++) begin
      dep_d[j] = dep_q[j] & ~clr_bits & ~kill;
      if (kill[j])
        dep_d[j] = '0;
      if (alloc_b_id[j])
        dep_d[j] = busy_q & ~clr_bits;
    end
    full_d = &busy_d;
    task_d = is_clr ? CLEAR : (is_sq ? SQUASH : NOTHING);
    rid_d  = res_ok ? res_b_id : '0;
    rv_d   = is_sq;
    rpc_d  = is_sq ? res_target : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      for (int j = 0; j < N_BR; j++)
        dep_q[j] <= '0;
      full_q <= 1'b0;
      task_q <= NOTHING;
      rid_q  <= '0;
      rv_q   <= 1'b0;
      rpc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      for (int j = 0; j < N_BR; j++)
        dep_q[j] <= dep_d[j];
      full_q <= full_d;
      task_q <= task_d;
      rid_q  <= rid_d;
      rv_q   <= rv_d;
      rpc_q  <= rpc_d;
      if (res_valid)
        assert (res_ok);
    end
  end

  assign cur_b_mask     = busy_q;
  assign full           = full_q;
  assign rem_br_task    = task_q;
  assign rem_b_id       = rid_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_br_tag_manager.sv
// Directed self-checking bench for br_tag_manager.
// Each task drives one scenario and checks results inline.
module tb_br_tag_manager;
  import br_tag_manager_pkg::*;

  logic        clock;
  logic        reset;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [3:0]  alloc_b_id;
  logic [3:0]  cur_b_mask;
  logic        full;
  logic        res_valid;
  br_task_t    res_task;
  logic [3:0]  res_b_id;
  logic [31:0] res_target;
  br_task_t    rem_br_task;
  logic [3:0]  rem_b_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_chk;
  int n_fail;

  br_tag_manager #(.N_BR(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_gnt      (alloc_gnt),
    .alloc_b_id     (alloc_b_id),
    .cur_b_mask     (cur_b_mask),
    .full           (full),
    .res_valid      (res_valid),
    .res_task       (res_task),
    .res_b_id       (res_b_id),
    .res_target     (res_target),
    .rem_br_task    (rem_br_task),
    .rem_b_id       (rem_b_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    alloc_req  = 1'b0;
    res_valid  = 1'b0;
    res_task   = NOTHING;
    res_b_id   = 4'b0000;
    res_target = 32'h0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1'b1;
      tick();
      alloc_req = 1'b0;
    end
  endtask

  task automatic resolve(input br_task_t t, input logic [3:0] id,
                         input logic [31:0] tgt);
    res_valid  = 1'b1;
    res_task   = t;
    res_b_id   = id;
    res_target = tgt;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (cur_b_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mask got %b exp 0000", cur_b_mask);
    end
    n_chk++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full got %b exp 0", full);
    end
    n_chk++;
    if (rem_br_task !== NOTHING || rem_b_id !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_rem got %0d/%b exp 0/0000",
               rem_br_task, rem_b_id);
    end
    n_chk++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_redir got %b/%h exp 0/0",
               redirect_valid, redirect_pc);
    end
    n_chk++;
    if (alloc_gnt !== 1'b0 || alloc_b_id !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_gnt got %b/%b exp 0/0000",
               alloc_gnt, alloc_b_id);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_id;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_id = 4'b0001 << i;
      alloc_req = 1'b1;
      #1;
      n_chk++;
      if (alloc_gnt !== 1'b1 || alloc_b_id !== exp_id) begin
        n_fail++;
        $display("FAIL fill_gnt%0d got %b/%b exp 1/%b",
                 i, alloc_gnt, alloc_b_id, exp_id);
      end
      if (i == 3) begin
        n_chk++;
        if (full !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_early_full got %b exp 0", full);
        end
      end
      tick();
    end
    n_chk++;
    if (full !== 1'b1 || cur_b_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL fill_full got %b/%b exp 1/1111",
               full, cur_b_mask);
    end
    #1;
    n_chk++;
    if (alloc_gnt !== 1'b0 || alloc_b_id !== 4'b0000) begin
      n_fail++;
      $display("FAIL fill_5th got %b/%b exp 0/0000",
               alloc_gnt, alloc_b_id);
    end
    alloc_req = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    alloc_n(3);
    resolve(CLEAR, 4'b0010, 32'h0);
    tick();
    idle_in();
    n_chk++;
    if (rem_br_task !== CLEAR || rem_b_id !== 4'b0010) begin
      n_fail++;
      $display("FAIL clr_bcast got %0d/%b exp 1/0010",
               rem_br_task, rem_b_id);
    end
    n_chk++;
    if (cur_b_mask !== 4'b0101) begin
      n_fail++;
      $display("FAIL clr_mask got %b exp 0101", cur_b_mask);
    end
    n_chk++;
    if (dut.dep_q[2] !== 4'b0001) begin
      n_fail++;
      $display("FAIL clr_depC got %b exp 0001", dut.dep_q[2]);
    end
    n_chk++;
    if (redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_noredir got %b exp 0", redirect_valid);
    end
    tick();
    n_chk++;
    if (rem_br_task !== NOTHING || rem_b_id !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_pulse got %0d/%b exp 0/0000",
               rem_br_task, rem_b_id);
    end
  endtask

  task automatic test_squash();
    do_reset();
    alloc_n(3);
    resolve(SQUASH, 4'b0001, 32'h1040);
    tick();
    idle_in();
    n_chk++;
    if (rem_br_task !== SQUASH || rem_b_id !== 4'b0001) begin
      n_fail++;
      $display("FAIL sq_bcast got %0d/%b exp 2/0001",
               rem_br_task, rem_b_id);
    end
    n_chk++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1040) begin
      n_fail++;
      $display("FAIL sq_redir got %b/%h exp 1/00001040",
               redirect_valid, redirect_pc);
    end
    n_chk++;
    if (cur_b_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL sq_mask got %b exp 0000", cur_b_mask);
    end
    tick();
    n_chk++;
    if (redirect_valid !== 1'b0 || rem_br_task !== NOTHING) begin
      n_fail++;
      $display("FAIL sq_pulse got %b/%0d exp 0/0",
               redirect_valid, rem_br_task);
    end
  endtask

  task automatic test_squash_mid();
    do_reset();
    alloc_n(4);
    resolve(SQUASH, 4'b0010, 32'h2000);
    tick();
    idle_in();
    n_chk++;
    if (cur_b_mask !== 4'b0001 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL sqmid_mask got %b/%b exp 0001/0",
               cur_b_mask, full);
    end
    n_chk++;
    if (rem_b_id !== 4'b0010) begin
      n_fail++;
      $display("FAIL sqmid_id got %b exp 0010", rem_b_id);
    end
  endtask

  task automatic test_alloc_squash();
    do_reset();
    alloc_n(2);
    alloc_req = 1'b1;
    resolve(SQUASH, 4'b0010, 32'h3000);
    #1;
    n_chk++;
    if (alloc_gnt !== 1'b0 || alloc_b_id !== 4'b0000) begin
      n_fail++;
      $display("FAIL asq_gnt got %b/%b exp 0/0000",
               alloc_gnt, alloc_b_id);
    end
    tick();
    idle_in();
    n_chk++;
    if (cur_b_mask !== 4'b0001 || rem_br_task !== SQUASH) begin
      n_fail++;
      $display("FAIL asq_mask got %b/%0d exp 0001/2",
               cur_b_mask, rem_br_task);
    end
  endtask

  task automatic test_alloc_clear();
    do_reset();
    alloc_n(2);
    alloc_req = 1'b1;
    resolve(CLEAR, 4'b0010, 32'h0);
    #1;
    n_chk++;
    if (alloc_gnt !== 1'b1 || alloc_b_id !== 4'b0100) begin
      n_fail++;
      $display("FAIL acl_gnt got %b/%b exp 1/0100",
               alloc_gnt, alloc_b_id);
    end
    tick();
    idle_in();
    n_chk++;
    if (cur_b_mask !== 4'b0101) begin
      n_fail++;
      $display("FAIL acl_mask got %b exp 0101", cur_b_mask);
    end
    n_chk++;
    if (dut.dep_q[2] !== 4'b0001) begin
      n_fail++;
      $display("FAIL acl_dep got %b exp 0001", dut.dep_q[2]);
    end
  endtask

  task automatic test_full_clear();
    do_reset();
    alloc_n(4);
    alloc_req = 1'b1;
    resolve(CLEAR, 4'b0001, 32'h0);
    #1;
    n_chk++;
    if (alloc_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL fc_nobypass got %b exp 0", alloc_gnt);
    end
    tick();
    res_valid = 1'b0;
    res_task  = NOTHING;
    res_b_id  = 4'b0000;
    n_chk++;
    if (full !== 1'b0 || cur_b_mask !== 4'b1110) begin
      n_fail++;
      $display("FAIL fc_drop got %b/%b exp 0/1110",
               full, cur_b_mask);
    end
    #1;
    n_chk++;
    if (alloc_gnt !== 1'b1 || alloc_b_id !== 4'b0001) begin
      n_fail++;
      $display("FAIL fc_regrant got %b/%b exp 1/0001",
               alloc_gnt, alloc_b_id);
    end
    tick();
    idle_in();
    n_chk++;
    if (full !== 1'b1 || cur_b_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL fc_refull got %b/%b exp 1/1111",
               full, cur_b_mask);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(3);
    reset = 1'b1;
    resolve(SQUASH, 4'b0001, 32'h4444);
    tick();
    reset = 1'b0;
    idle_in();
    n_chk++;
    if (cur_b_mask !== 4'b0000 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_mask got %b/%b exp 0000/0",
               cur_b_mask, full);
    end
    n_chk++;
    if (rem_br_task !== NOTHING || rem_b_id !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_rem got %0d/%b exp 0/0000",
               rem_br_task, rem_b_id);
    end
    n_chk++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_redir got %b/%h exp 0/0",
               redirect_valid, redirect_pc);
    end
    n_chk++;
    if (dut.dep_q[2] !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_dep got %b exp 0000", dut.dep_q[2]);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle_in();
    test_reset();
    test_fill();
    test_clear();
    test_squash();
    test_squash_mid();
    test_alloc_squash();
    test_alloc_clear();
    test_full_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/br_tag_manager.md
# br_tag_manager

Allocates one-hot branch IDs (b_id) to branches at dispatch, tracks which in-flight branches each branch depends on, and retires IDs when the branch FU resolves them. It sits between dispatch and the branch FU. It consumes the FU's resolution outputs (task, b_id, target) and drives the registered `rem_br_task`/`rem_b_id` broadcast that every RS, FU and ROB uses to clear or squash b_mask bits. On a mispredict it also issues the front-end redirect.

## Interface
- `N_BR`, default `` `N_BR `` (4): number of simultaneously in-flight branches; equals the BR_MASK width.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `alloc_req` in 1: dispatch has a branch this cycle.
- `alloc_gnt` out 1: combinational; an ID is granted this cycle.
- `alloc_b_id` out BR_MASK: combinational one-hot ID granted; '0 when `alloc_gnt`=0.
- `cur_b_mask` out BR_MASK: registered set of allocated IDs; dispatch stamps it as the b_mask of every instruction.
- `full` out 1: registered; asserted when `cur_b_mask` is all ones.
- `res_valid` in 1: branch FU `data_ready`.
- `res_task` in BR_TASK: branch FU `br_task` (CLEAR/SQUASH).
- `res_b_id` in BR_MASK: one-hot b_id of the resolving branch.
- `res_target` in ADDR: branch FU result PC.
- `rem_br_task` out BR_TASK: registered broadcast.
- `rem_b_id` out BR_MASK: registered broadcast ID.
- `redirect_valid` out 1: registered; fetch redirect.
- `redirect_pc` out ADDR: registered redirect target.

## Operation
- State:
  - `busy` (BR_MASK).
  - `dep[N_BR]` (BR_MASK each): `dep[i]` holds the IDs older than i at allocation.
  - Output registers.
- Allocation:
  - If `alloc_req` and `busy` is not all ones and no SQUASH is resolving this cycle, grant the lowest-index clear bit of `busy`.
  - Set that bit in `busy` at the next edge.
  - Load `dep[i] <= busy & ~clr_bits`, where `clr_bits` = `res_b_id` when a CLEAR resolves this cycle, else 0.
- Resolution applies only when `res_valid` is high and `res_b_id` is a single bit set in `busy`. Otherwise the input is ignored and an assertion fires.
- CLEAR of bit b:
  - Clear b in `busy`.
  - Clear column b in every `dep[j]`.
  - Broadcast `rem_br_task`=CLEAR, `rem_b_id`=b.
- SQUASH of bit b:
  - Free b and every j with `dep[j][b]`=1; these are younger branches.
  - Zero `dep` rows for freed IDs.
  - Broadcast SQUASH with `rem_b_id`=b only; downstream units squash anything whose b_mask contains b.
  - `redirect_valid`=1, `redirect_pc`=`res_target`.
- An ID freed at edge t is first re-grantable in the cycle after t. Grants use registered `busy` only, with no same-cycle bypass.
- Alloc with simultaneous SQUASH: `alloc_gnt`=0, because the dispatching branch is on the wrong path.
- Alloc with simultaneous CLEAR: the grant proceeds, and the new `dep` row excludes the cleared ID.
- Only one resolution per cycle; the branch FU is single-issue.

## Timing
- Reset values: `busy`=0, all `dep`=0, `cur_b_mask`=0, `full`=0, `rem_br_task`=NOTHING, `rem_b_id`=0, `redirect_valid`=0, `redirect_pc`=0.
- Reset mid-operation discards all in-flight IDs at the next edge without any broadcast.
- `alloc_gnt`/`alloc_b_id` are combinational from `alloc_req` and registered state.
- Grant to visible in `cur_b_mask`: 1 cycle.
- Resolve to broadcast and redirect: 1 cycle, with a registered output.
- `rem_br_task`, `redirect_valid` and `rem_b_id` are single-cycle pulses. With no valid resolve they return to NOTHING, 0 and 0 respectively.
- `full` is high exactly while all N_BR IDs are busy. While `full`, `alloc_req` yields `alloc_gnt`=0; dispatch stalls.

## Structure
- Add to sys_defs.svh: `` `N_BR ``, BR_MASK (logic [`N_BR-1:0]), and BR_TASK enum {NOTHING, CLEAR, SQUASH}, already shared with the branch FU and the RS.
- One sub-module, `br_psel`: a parameterised lowest-index-first one-hot priority selector over ~`busy`.
- Everything else is flat registers plus combinational next-state.

## Test plan
- Reset, then 4 back-to-back `alloc_req` → IDs 0001, 0010, 0100, 1000 in order; `full`=1 after the 4th edge; a 5th request gets `alloc_gnt`=0.
- Allocate A=0001, B=0010, C=0100; CLEAR B → next cycle `rem_br_task`=CLEAR, `rem_b_id`=0010, `cur_b_mask`=0101, and `dep[C]`=0001.
- Allocate A, B, C; SQUASH A with `res_target`=0x1040 → next cycle SQUASH, `rem_b_id`=0001, `redirect_valid`=1, `redirect_pc`=0x1040, `cur_b_mask`=0000.
- With 0011 busy, `alloc_req` in the same cycle as SQUASH 0010 → `alloc_gnt`=0 and `cur_b_mask`=0001 next cycle. Repeat with CLEAR 0010 → grant 0100; its `dep`=0001.
- Full (1111), CLEAR 0001 → `full` drops next cycle; a request in that cycle is granted 0001.
- Assert `reset` while three IDs are busy and a SQUASH resolves in the same cycle → all outputs take reset values next cycle, with no broadcast.
